// File: rtl/arm_pkg.sv
// Shared ARM encoding constants and the field tuple used by the instruction encoder.
package arm_pkg;

  localparam logic [1:0] CLASS_DP  = 2'b00;
  localparam logic [1:0] CLASS_MEM = 2'b01;
  localparam logic [1:0] CLASS_BR  = 2'b10;
  localparam logic [1:0] CLASS_ILL = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_EOR = 4'b0001;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [3:0] OP_BR   = 4'b1010;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef struct packed {
    logic [1:0]  cls;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s;
    logic        imm;
    logic        load;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
  } arm_fields_t;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || (cmd == CMD_EOR);
  endfunction

endpackage

// File: rtl/arm_instr_encoder_if.sv
// Sequencer-to-encoder bus: base load, field tuple handshake and encoded word handshake.
interface arm_instr_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              base_ld;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_class;
  logic [3:0]        in_cond;
  logic [3:0]        in_cmd;
  logic              in_s;
  logic              in_imm;
  logic              in_load;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [11:0]       in_src2;
  logic [ADDR_W-1:0] in_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [15:0]       count;

  modport master (
    output base_ld, base_addr, in_valid, in_class, in_cond, in_cmd, in_s, in_imm,
           in_load, in_rn, in_rd, in_src2, in_target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, count
  );

  modport slave (
    input  base_ld, base_addr, in_valid, in_class, in_cond, in_cmd, in_s, in_imm,
           in_load, in_rn, in_rd, in_src2, in_target, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, count
  );
endinterface

// File: rtl/arm_instr_encoder_field_pack.sv
// Combinational field packer: field tuple + current PC -> 32-bit ARM word.
// Optional ARM_ENCODE_CHECK_EN flags unencodable tuples and zeroes their word.
module arm_field_pack
  import arm_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  arm_fields_t       fields,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr_c,
  output logic              err_c
);

  logic [ADDR_W-1:0] diff_c;
  logic [ADDR_W-1:0] off_c;

  // PC reads two words ahead of the branch itself.
  always_comb begin
    diff_c = target - (pc + ADDR_W'(8));
    off_c  = ADDR_W'($signed(diff_c) >>> 2);
  end

`ifdef ARM_ENCODE_CHECK_EN
  logic [ADDR_W-24:0] off_hi_c;
  logic               off_ok_c;

  always_comb begin
    off_hi_c = off_c[ADDR_W-1:23];
    off_ok_c = (&off_hi_c) | ~(|off_hi_c);
  end
`else
  logic unused_off_hi;
  assign unused_off_hi = ^off_c[ADDR_W-1:24];
`endif

  always_comb begin
    instr_c = '0;
    err_c   = 1'b0;
    case (fields.cls)
      CLASS_DP:  instr_c = {fields.cond, OP_DP, fields.imm, fields.cmd, fields.s,
                            fields.rn, fields.rd, fields.src2};
      CLASS_MEM: instr_c = {fields.cond, OP_MEM, ~fields.imm, 1'b1, 1'b1, 1'b0, 1'b0,
                            fields.load, fields.rn, fields.rd, fields.src2};
      CLASS_BR:  instr_c = {fields.cond, OP_BR, off_c[23:0]};
      default:   instr_c = {fields.cond, fields.cls, fields.imm, fields.cmd, fields.s,
                            fields.rn, fields.rd, fields.src2};
    endcase
`ifdef ARM_ENCODE_CHECK_EN
    err_c = (fields.cls == CLASS_ILL) ||
            ((fields.cls == CLASS_DP) && !cmd_supported(fields.cmd)) ||
            ((fields.cls == CLASS_BR) && ((target[1:0] != 2'b00) || !off_ok_c));
    if (err_c) instr_c = '0;
`endif
  end

endmodule

// File: rtl/arm_instr_encoder.sv
// ARM instruction encoder: tracks the write PC and registers one encoded word with valid/ready.
// Build option ARM_ENCODE_CHECK_EN enables encoding error detection on out_err.
module arm_instr_encoder
  import arm_pkg::*;
#(
  parameter int unsigned         ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]   BASE_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  arm_instr_encoder_if.slave  bus
);

  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_err_q;
  logic [15:0]       count_q;
  logic [ADDR_W-1:0] pc_q;

  arm_fields_t fields_c;
  logic [31:0] instr_c;
  logic        err_c;
  logic        in_ready_c;
  logic        accept_c;
  logic        emit_c;

  always_comb begin
    fields_c = '{cls: bus.in_class, cond: bus.in_cond, cmd: bus.in_cmd, s: bus.in_s,
                 imm: bus.in_imm, load: bus.in_load, rn: bus.in_rn, rd: bus.in_rd,
                 src2: bus.in_src2};
    in_ready_c = ~bus.base_ld & (~out_valid_q | bus.out_ready);
    accept_c   = bus.in_valid & in_ready_c;
    emit_c     = out_valid_q & bus.out_ready;
  end

  arm_field_pack #(.ADDR_W(ADDR_W)) u_pack (
    .fields  (fields_c),
    .target  (bus.in_target),
    .pc      (pc_q),
    .instr_c (instr_c),
    .err_c   (err_c)
  );

  // Output stage, PC and emitted-word counter; base_ld resets the count but keeps a pending word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
      count_q     <= '0;
      pc_q        <= BASE_RESET;
    end else begin
      if (bus.base_ld) begin
        pc_q    <= bus.base_addr & ~ADDR_W'(3);
        count_q <= '0;
      end else if (emit_c) begin
        count_q <= count_q + 16'd1;
      end
      if (accept_c) begin
        out_valid_q <= 1'b1;
        out_instr_q <= instr_c;
        out_addr_q  <= pc_q;
        out_err_q   <= err_c;
        pc_q        <= pc_q + ADDR_W'(4);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;
  assign bus.count     = count_q;

endmodule
